// File: rtl/rng_pkg.sv
// Shared definitions for the xorshift64 RNG engine: FSM encoding, shift constants,
// zero-seed fallback and the little-endian byte lane helper.
package rng_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StStore
  } rng_state_e;

  localparam int unsigned XS_A = 13;
  localparam int unsigned XS_B = 7;
  localparam int unsigned XS_C = 17;

  localparam logic [63:0] SEED_FALLBACK = 64'h9E37_79B9_7F4A_7C15;

  // Bit position of byte k inside a little-endian 64-bit word.
  function automatic logic [5:0] byte_lsb(input logic [2:0] k);
    return {k, 3'b000};
  endfunction

endpackage

// File: rtl/xorshift64_step.sv
// Combinational xorshift64 next-state function (13/7/17 triple).
module xorshift64_step
  import rng_pkg::*;
(
  input  logic [63:0] x_i,
  output logic [63:0] y_o
);

  logic [63:0] s1;
  logic [63:0] s2;

  assign s1  = x_i ^ (x_i << XS_A);
  assign s2  = s1 ^ (s1 >> XS_B);
  assign y_o = s2 ^ (s2 << XS_C);

endmodule

// File: rtl/rng_xorshift_engine.sv
// xorshift64 generator: loads a seed byte-wise from the state store, streams 32-bit
// words over valid/ready and writes the advanced state back on commit.
module rng_xorshift_engine
  import rng_pkg::*;
#(
  parameter int unsigned NUM_BYTES    = 32,
  parameter int unsigned STATE_OFFSET = 0,
  parameter int unsigned ADDR_W       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              commit,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              busy,
  output logic              seed_zero
);

  if (STATE_OFFSET + 8 > NUM_BYTES) begin : g_bad_offset
    $error("STATE_OFFSET + 8 must not exceed NUM_BYTES");
  end
  if ((64'd1 << ADDR_W) < 64'(NUM_BYTES)) begin : g_bad_addr_w
    $error("ADDR_W too small for NUM_BYTES");
  end

  rng_state_e  fsm_q, fsm_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        rd_done_q, rd_done_d;
  logic        cap_vld_q, cap_vld_d;
  logic [2:0]  cap_idx_q, cap_idx_d;
  logic [63:0] x_q, x_d;
  logic        seed_zero_q, seed_zero_d;
  logic [63:0] x_next;
  logic [63:0] assembled;

  xorshift64_step u_step (
    .x_i (x_q),
    .y_o (x_next)
  );

  always_comb begin
    fsm_d       = fsm_q;
    cnt_d       = cnt_q;
    rd_done_d   = rd_done_q;
    cap_vld_d   = 1'b0;
    cap_idx_d   = cap_idx_q;
    x_d         = x_q;
    seed_zero_d = seed_zero_q;
    assembled   = x_q;
    rd_en       = 1'b0;
    rd_addr     = '0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    out_valid   = 1'b0;

    unique case (fsm_q)
      StIdle: begin
        if (start) begin
          fsm_d       = StLoad;
          cnt_d       = 3'd0;
          rd_done_d   = 1'b0;
          seed_zero_d = 1'b0;
        end
      end
      StLoad: begin
        if (!rd_done_q) begin
          rd_en     = 1'b1;
          rd_addr   = ADDR_W'(STATE_OFFSET) + ADDR_W'(cnt_q);
          cap_vld_d = 1'b1;
          cap_idx_d = cnt_q;
          cnt_d     = cnt_q + 3'd1;
          if (cnt_q == 3'd7) rd_done_d = 1'b1;
        end
        // Read data trails the strobe by one cycle, so capture uses the delayed index.
        if (cap_vld_q) begin
          assembled[byte_lsb(cap_idx_q) +: 8] = rd_data;
          x_d = assembled;
          if (cap_idx_q == 3'd7) begin
            fsm_d = StRun;
            if (assembled == 64'd0) begin
              x_d         = SEED_FALLBACK;
              seed_zero_d = 1'b1;
            end
          end
        end
      end
      StRun: begin
        out_valid = 1'b1;
        if (out_ready) x_d = x_next;
        if (commit) begin
          fsm_d = StStore;
          cnt_d = 3'd0;
        end
      end
      StStore: begin
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(STATE_OFFSET) + ADDR_W'(cnt_q);
        wr_data = x_q[byte_lsb(cnt_q) +: 8];
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) fsm_d = StIdle;
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q       <= StIdle;
      cnt_q       <= '0;
      rd_done_q   <= 1'b0;
      cap_vld_q   <= 1'b0;
      cap_idx_q   <= '0;
      x_q         <= '0;
      seed_zero_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      rd_done_q   <= rd_done_d;
      cap_vld_q   <= cap_vld_d;
      cap_idx_q   <= cap_idx_d;
      x_q         <= x_d;
      seed_zero_q <= seed_zero_d;
    end
  end

  assign out_data  = x_q[31:0];
  assign busy      = (fsm_q != StIdle);
  assign seed_zero = seed_zero_q;

endmodule

// File: doc/rng_xorshift_engine.md
# rng_xorshift_engine

Sequential xorshift64 generator that sits directly downstream of the byte-addressed RNG state store. It reads a 64-bit seed from the store over a byte-wide read port, produces one 32-bit random word per valid/ready handshake, and on request writes the advanced state back to the store byte by byte. All byte order is little endian: lowest address holds the least-significant byte.

## Interface
- `NUM_BYTES`, 32: size of the attached state store in bytes.
- `STATE_OFFSET`, 0: byte offset of the 64-bit state within the store. Legal range is STATE_OFFSET + 8 <= NUM_BYTES, checked at elaboration.
- `ADDR_W`, 5: store address width. Requires 2^ADDR_W >= NUM_BYTES.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse; begins a seed load. Sampled only in IDLE.
- `commit`  in  1  one-cycle pulse; begins writeback of the current state. Sampled only in RUN.
- `rd_en`  out  1  store byte read strobe.
- `rd_addr`  out  ADDR_W  store read address.
- `rd_data`  in  8  store read data, valid exactly one cycle after `rd_en`.
- `wr_en`  out  1  store byte write strobe.
- `wr_addr`  out  ADDR_W  store write address.
- `wr_data`  out  8  store write data.
- `out_valid`  out  1  random word available.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  32  random word, equal to the low 32 bits of the state register.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `seed_zero`  out  1  sticky flag: the loaded seed was all-zero. Cleared by the next `start`.

## Operation
- FSM states are IDLE, LOAD, RUN and STORE.
- **IDLE:**
  - `start` moves the FSM to LOAD and clears `seed_zero`.
  - `commit` is ignored.
- **LOAD:**
  - Issues 8 reads, one per cycle, at addresses STATE_OFFSET+0 through STATE_OFFSET+7.
  - Each returned byte k is captured into state[8k+7:8k].
  - After byte 7 is captured the FSM moves to RUN.
  - If the assembled state is 0, the state is replaced by SEED_FALLBACK = 64'h9E3779B97F4A7C15 and `seed_zero` is set. Xorshift never leaves zero, so this substitution is mandatory.
- **RUN:**
  - `out_valid` = 1.
  - On `out_valid && out_ready` the state is updated in order: x ^= x<<13; x ^= x>>7; x ^= x<<17. All arithmetic is 64-bit with shifted-out bits discarded.
  - `out_data` holds steady while `out_ready` = 0.
  - On `commit`, the FSM moves to STORE and `out_valid` drops the next cycle.
  - If a handshake and `commit` occur in the same cycle, the handshake is honoured first and the advanced state is the one stored.
- **STORE:**
  - Issues 8 writes, one per cycle, of state byte k to STATE_OFFSET+k for k = 0 through 7.
  - Then returns to IDLE.
  - `start` is ignored.
- `start` outside IDLE and `commit` outside RUN are dropped with no effect.
- The engine never reads or writes outside STATE_OFFSET through STATE_OFFSET+7.

## Timing
- Reset values: state = 0, FSM = IDLE, and `rd_en`, `wr_en`, `out_valid`, `busy`, `seed_zero` all 0. Address, data and `out_data` outputs are 0.
- LOAD latency:
  - With `start` in cycle 0, `rd_en` is high in cycles 1 through 8.
  - `rd_data` is captured in cycles 2 through 9.
  - `out_valid` rises in cycle 10.
- Throughput in RUN is one word per cycle when `out_ready` is held at 1. `out_data` updates in the cycle after each handshake.
- STORE latency:
  - With `commit` in cycle c, `wr_en` is high in cycles c+1 through c+8.
  - `busy` falls in cycle c+9.
- An asynchronous reset mid-LOAD or mid-STORE aborts immediately. A partial write leaves the store holding mixed old and new bytes. That is accepted; software must re-commit.

## Structure
- Shared package `rng_pkg` holds:
  - the FSM state encoding,
  - shift constants XS_A = 13, XS_B = 7, XS_C = 17,
  - SEED_FALLBACK,
  - the little-endian byte-index helper.
- One natural sub-module, `xorshift64_step`: a combinational 64-bit to 64-bit next-state function. It is reused by future wider or parallel generators.
- The top level is the FSM, a 3-bit byte counter, the 64-bit state register and the port muxing.

## Test plan
- Seed bytes 01 00 00 00 00 00 00 00, then `start` -> `out_valid` in cycle 10 with `out_data` = 0x00000001. After one handshake `out_data` = 0x40822041.
- After one handshake from seed 1, `commit` -> the store receives 41 20 82 40 00 00 00 00 at STATE_OFFSET+0 through +7, one per cycle. `busy` falls 9 cycles after `commit`.
- All-zero seed -> `seed_zero` = 1 and `out_data` = 0x7F4A7C15. A following `start` clears `seed_zero`.
- Hold `out_ready` = 0 for 5 cycles in RUN -> `out_data` is stable. Then `out_ready` = 1 for 3 cycles -> 3 distinct words that match the reference xorshift64 sequence.
- Assert handshake and `commit` in the same cycle from seed 1 -> the stored bytes equal the advanced state 0x40822041. `start` pulsed during STORE is ignored.
- Pull `rst` low in the middle of LOAD, at the fourth read -> all outputs go to reset values asynchronously. A new `start` reloads correctly from address STATE_OFFSET+0.
